// File: rtl/float16_multiplier.sv
// IEEE 754 binary16 multiplier, round-to-nearest-even, full subnormal/Inf/NaN support.
// Latency: 1 cycle (combinational core, registered result and out_valid).
// Backpressure: none; a new operand pair is accepted every cycle.
module float16_multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   output logic [15:0] result
);

   localparam int FLOAT_LEN = 16;
   localparam int EXP_LEN   = 5;
   localparam int MANT_LEN  = 10;
   localparam int EXP_BIAS  = 15;

   localparam logic [FLOAT_LEN-1:0] QNAN = 16'h7E00;

   // operand fields
   logic                sa, sb, sr;
   logic [EXP_LEN-1:0]  ea, eb;
   logic [MANT_LEN-1:0] ma, mb;
   logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   // finite datapath
   logic [MANT_LEN:0]   sig_a, sig_b;
   logic [EXP_LEN-1:0]  exp_a, exp_b;
   logic [21:0]         p, pn, shifted;
   logic [4:0]          lz;
   logic signed [7:0]   e_work, sh;
   logic [5:0]          sh_amt;
   logic [43:0]         wide;
   logic                lost, g, r, st, inc;
   logic [EXP_LEN-1:0]  exp_field;
   logic [14:0]         mag;
   logic [15:0]         prod;

   // unpack and classify operands; subnormals get effective exponent 1 and no hidden bit
   always_comb begin
      sa     = a[15];
      sb     = b[15];
      ea     = a[14:10];
      eb     = b[14:10];
      ma     = a[9:0];
      mb     = b[9:0];
      sr     = sa ^ sb;
      a_nan  = (ea == 5'h1F) && (ma != '0);
      b_nan  = (eb == 5'h1F) && (mb != '0);
      a_inf  = (ea == 5'h1F) && (ma == '0);
      b_inf  = (eb == 5'h1F) && (mb == '0);
      a_zero = (ea == '0) && (ma == '0);
      b_zero = (eb == '0) && (mb == '0);
      sig_a  = {(ea != '0), ma};
      sig_b  = {(eb != '0), mb};
      exp_a  = (ea == '0) ? 5'd1 : ea;
      exp_b  = (eb == '0) ? 5'd1 : eb;
   end

   // multiply, normalise, denormalise and round the finite product
   always_comb begin
      p  = {11'b0, sig_a} * {11'b0, sig_b};
      lz = 5'd0;
      for (int i = 0; i < 22; i++) begin
         if (p[i]) lz = 5'(21 - i);
      end
      // left-justify so the leading one sits at bit 21; nothing is lost by this shift
      pn     = p << lz;
      // bit 21 of pn has weight 2^1 of the raw product, hence the +1
      e_work = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b})
               - 8'(EXP_BIAS) + 8'sd1 - $signed({3'b000, lz});
      sh     = 8'sd1 - e_work;
      if (e_work <= 8'sd0) begin
         sh_amt = (sh > 8'sd23) ? 6'd23 : sh[5:0];
      end else begin
         sh_amt = 6'd0;
      end
      wide    = {pn, 22'b0} >> sh_amt;
      shifted = wide[43:22];
      lost    = |wide[21:0];
      g       = shifted[10];
      r       = shifted[9];
      st      = (|shifted[8:0]) | lost;
      inc     = g & (r | st | shifted[11]);
      // the hidden bit survives only on the normal path; denormalised results use field 0
      exp_field = shifted[21] ? e_work[4:0] : 5'd0;
      // mantissa carry ripples into the exponent: 0x3FF->0x400 and 30.x->31 (Inf) fall out naturally
      mag = {exp_field, shifted[20:11]} + {14'b0, inc};
   end

   // resolve special operands in priority order, then overflow
   always_comb begin
      if (a_nan || b_nan) begin
         prod = QNAN;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         prod = QNAN;
      end else if (a_inf || b_inf) begin
         prod = {sr, 5'h1F, 10'h000};
      end else if (a_zero || b_zero) begin
         prod = {sr, 15'h0000};
      end else if (e_work >= 8'sd31) begin
         prod = {sr, 5'h1F, 10'h000};
      end else begin
         prod = {sr, mag};
      end
   end

   // output register: result holds when no new operands arrive
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= 16'h0000;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result <= prod;
         end
      end
   end

endmodule

// File: tb/tb_float16_multiplier.sv
// Directed-vector bench for float16_multiplier with hand-computed fp16 products.
// Latency: each vector is checked one cycle after it is applied.
// Backpressure: none; vectors stream back-to-back, then hold and reset sequences.
module tb_float16_multiplier;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   float16_multiplier dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic add(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] ve);
      vec_t v;
      v.a   = va;
      v.b   = vb;
      v.exp = ve;
      vecs.push_back(v);
   endtask

   initial begin
      // basic, signs and ties
      add(16'h4000, 16'h4200, 16'h4600);
      add(16'h3E00, 16'hC100, 16'hC380);
      add(16'h3C01, 16'h3E00, 16'h3E02);
      add(16'h3C01, 16'h3C01, 16'h3C02);
      add(16'h3C00, 16'h3C00, 16'h3C00);
      add(16'hC000, 16'hC000, 16'h4400);
      add(16'h7BFF, 16'h3800, 16'h77FF);
      // overflow and specials
      add(16'h7BFF, 16'h4000, 16'h7C00);
      add(16'h7BFF, 16'h3C01, 16'h7C00);
      add(16'hFC00, 16'h4000, 16'hFC00);
      add(16'h7C00, 16'hC000, 16'hFC00);
      add(16'h7C00, 16'h0000, 16'h7E00);
      add(16'h0000, 16'hFC00, 16'h7E00);
      add(16'h7E01, 16'h3C00, 16'h7E00);
      add(16'hFE00, 16'h3C00, 16'h7E00);
      add(16'h8000, 16'h3C00, 16'h8000);
      add(16'h8000, 16'h8000, 16'h0000);
      // subnormals and underflow
      add(16'h0400, 16'h3800, 16'h0200);
      add(16'h0001, 16'h3800, 16'h0000);
      add(16'h0003, 16'h3800, 16'h0002);
      add(16'h0001, 16'h4000, 16'h0002);
      add(16'h0001, 16'h3C00, 16'h0001);
      add(16'h0200, 16'h4000, 16'h0400);
      add(16'h03FF, 16'h4000, 16'h07FE);
      add(16'h3BFF, 16'h0400, 16'h0400);
      add(16'h0001, 16'h0001, 16'h0000);
      add(16'h8001, 16'h0001, 16'h8000);
      add(16'h0400, 16'h0400, 16'h0000);

      // reset held for two cycles while valid operands are presented
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 16'h4000;
      b        = 16'h4200;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("reset_out_valid_%0d", i), {15'b0, out_valid}, 16'h0000);
         chk($sformatf("reset_result_%0d", i), result, 16'h0000);
      end
      rst = 1'b0;

      // table vectors streamed back-to-back with in_valid held high
      foreach (vecs[i]) begin
         a        = vecs[i].a;
         b        = vecs[i].b;
         in_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d_out_valid", i), {15'b0, out_valid}, 16'h0001);
         chk($sformatf("vec%0d_%h_x_%h", i, vecs[i].a, vecs[i].b), result, vecs[i].exp);
      end

      // hold: in_valid low keeps the last result and drops out_valid
      in_valid = 1'b0;
      a        = 16'h3C00;
      b        = 16'h3C00;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("hold_out_valid_%0d", i), {15'b0, out_valid}, 16'h0000);
         chk($sformatf("hold_result_%0d", i), result, 16'h0000);
      end

      // load a non-zero value, then hold it
      in_valid = 1'b1;
      a        = 16'h3E00;
      b        = 16'hC100;
      @(negedge clk);
      chk("load_result", result, 16'hC380);
      in_valid = 1'b0;
      a        = 16'h4000;
      b        = 16'h4000;
      @(negedge clk);
      chk("hold2_out_valid", {15'b0, out_valid}, 16'h0000);
      chk("hold2_result", result, 16'hC380);

      // reset while a product is in flight discards it
      in_valid = 1'b1;
      a        = 16'h4000;
      b        = 16'h4200;
      rst      = 1'b1;
      @(negedge clk);
      chk("midreset_out_valid", {15'b0, out_valid}, 16'h0000);
      chk("midreset_result", result, 16'h0000);
      rst = 1'b0;
      @(negedge clk);
      chk("postreset_out_valid", {15'b0, out_valid}, 16'h0001);
      chk("postreset_result", result, 16'h4600);
      in_valid = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/float16_multiplier.md
Name: float16_multiplier

Overview:
- Single-cycle-registered IEEE 754 binary16 (half-precision) multiplier used as an arithmetic primitive in the activation accelerator datapath.
- Takes two fp16 operands and produces their correctly rounded fp16 product (round-to-nearest-even) one clock later.
- Full support for subnormals, signed zeros, infinities and NaN.

Parameters:
- FLOAT_LEN, 16: total float width; fixed, not meant to be overridden.
- EXP_LEN, 5: exponent field width.
- MANT_LEN, 10: stored mantissa field width (hidden bit not stored).
- EXP_BIAS, 15: exponent bias.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a and b are valid this cycle.
- a  input  16  operand A, fp16 {sign, exp[4:0], mant[9:0]}.
- b  input  16  operand B, fp16.
- out_valid  output  1  result holds a new product.
- result  output  16  fp16 product a*b.

Behaviour:
- Reset (rst=1 at a rising edge): out_valid<=0, result<=16'h0000. This also applies mid-operation: a product in flight is discarded.
- Latency is exactly 1 cycle. At an edge with in_valid=1, result<=fp16(a*b) and out_valid<=1.
- At an edge with in_valid=0, out_valid<=0 and result holds its previous value.
- No backpressure. A new operand pair is accepted every cycle.
- The arithmetic core is purely combinational. Only result and out_valid are registered.
- Sign: result sign = a[15]^b[15] for every case except NaN.

Special cases, checked in priority order:
1. Either operand NaN (exp=31, mant!=0) -> 16'h7E00 (canonical quiet NaN, sign 0).
2. Inf * zero, in either order -> 16'h7E00.
3. Either operand Inf -> {s, 5'h1F, 10'h000}.
4. Either operand zero -> {s, 15'h0}, signed zero.

Finite datapath:
- Significand: normal operands use {1, mant} with effective exponent exp. Subnormal operands use {0, mant} with effective exponent 1.
- Product: 11x11 unsigned multiply gives a 22-bit product P. Unbiased working exponent E = ea + eb - 15.
- Normalize so the leading 1 sits at the hidden-bit position:
  - If P[21]=1, shift right 1 and E+1.
  - Otherwise, left-shift by the leading-zero count (subnormal inputs) and decrement E accordingly.
- Keep guard, round and sticky bits through every shift. Sticky is the OR of all discarded bits.
- If E <= 0: denormalize by right shift (1-E), accumulating sticky, and set the exponent field to 0. Shifts >= 12 yield a significand of 0, with sticky set if P was nonzero.
- Rounding is RNE: increment when G & (R | S | LSB).
  - Mantissa carry-out increments the exponent and resets the mantissa to 0.
  - A subnormal that rounds up into 0x400 becomes the smallest normal, 0x0400.
- Overflow: if the final exponent >= 31 (before or after rounding) -> {s, 5'h1F, 10'h000}.
- Underflow to zero -> {s, 15'h0}.
- Results must be bit-exact to IEEE 754 binary16 RNE multiplication.

Test Plan:
- Basic: rst for 2 cycles, then in_valid=1, a=0x4000 (2.0), b=0x4200 (3.0) -> next cycle out_valid=1, result=0x4600 (6.0). While held in reset: out_valid=0, result=0x0000.
- Signs and ties: a=0x3E00 (1.5), b=0xC100 (-2.5) -> 0xC380 (-3.75). RNE tie case a=0x3C01, b=0x3E00 -> 0x3E02. a=0x3C01, b=0x3C01 -> 0x3C02.
- Overflow and specials:
  - 0x7BFF * 0x4000 -> 0x7C00.
  - 0xFC00 * 0x4000 -> 0xFC00.
  - 0x7C00 * 0x0000 -> 0x7E00.
  - 0x7E01 * 0x3C00 -> 0x7E00.
  - 0x8000 * 0x3C00 -> 0x8000.
- Subnormals:
  - 0x0400 * 0x3800 -> 0x0200.
  - 0x0001 * 0x3800 -> 0x0000 (tie rounds to even).
  - 0x0001 * 0x4000 -> 0x0002.
  - 0x0200 * 0x4000 -> 0x0400.
- Throughput, hold and reset: back-to-back in_valid=1 for 3 cycles with distinct pairs -> 3 consecutive correct results. Then in_valid=0 -> out_valid=0 and result unchanged. Asserting rst while in_valid=1 -> out_valid=0 and result=0x0000 on the next cycle.
- Random sweep: 10k random operand pairs (seed 1234), including subnormal and special encodings -> result bit-exact against a software fp16 RNE reference model.
